// File: rtl/vector_elem_sequencer.sv
// Vector element sequencer: walks a register group one 32-bit beat per handshake.
// Optional abort input when VSEQ_ABORT_EN is defined.
module vector_elem_sequencer #(
  parameter int VLENB = 4,
  parameter int VL_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [VL_W-1:0] vl,
  input  logic [1:0]      vsew,
  input  logic [1:0]      vlmul,
`ifdef VSEQ_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy,
  output logic            done,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [2:0]      op_reg_off,
  output logic [VL_W-1:0] op_elem_idx,
  output logic [3:0]      op_byte_en,
  output logic            op_first,
  output logic            op_last
);

  localparam logic [2:0] BYTES = 3'(VLENB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sew_q, sew_d;
  logic [5:0]  evl_q, evl_d;
  logic [2:0]  beat_q, beat_d;

  logic [1:0]  sew_in;
  logic [2:0]  per_in;
  logic [5:0]  vlmax_in;
  logic [5:0]  vl6_in;
  logic [5:0]  evl_in;

  logic [2:0]  per_reg;
  logic [4:0]  elem5;
  logic [5:0]  elem6;
  logic [5:0]  elem_end;
  logic        is_last;
  logic [3:0]  be;
  logic        run;
  logic        abort_req;

`ifdef VSEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Reserved SEW encoding behaves as 32-bit elements.
  always_comb begin
    sew_in   = (vsew == 2'd3) ? 2'd2 : vsew;
    per_in   = BYTES >> sew_in;
    vlmax_in = {3'b000, per_in} << vlmul;
    vl6_in   = 6'(vl);
    evl_in   = (vl6_in < vlmax_in) ? vl6_in : vlmax_in;
  end

  always_comb begin
    per_reg  = BYTES >> sew_q;
    elem5    = {2'b00, beat_q} << (2'd2 - sew_q);
    elem6    = {1'b0, elem5};
    elem_end = elem6 + {3'b000, per_reg};
    is_last  = (elem_end >= evl_q);
  end

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      (sew_q == 2'd0): begin
        be[0] = (elem6 < evl_q);
        be[1] = ((elem6 + 6'd1) < evl_q);
        be[2] = ((elem6 + 6'd2) < evl_q);
        be[3] = ((elem6 + 6'd3) < evl_q);
      end
      (sew_q == 2'd1): begin
        be[1:0] = {2{elem6 < evl_q}};
        be[3:2] = {2{(elem6 + 6'd1) < evl_q}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sew_d   = sew_q;
    evl_d   = evl_q;
    beat_d  = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sew_d   = sew_in;
          evl_d   = evl_in;
          beat_d  = 3'd0;
          state_d = (evl_in == 6'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort_req) begin
          state_d = S_IDLE;
        end else if (op_ready) begin
          if (is_last) state_d = S_DONE;
          else beat_d = beat_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sew_q   <= 2'd0;
      evl_q   <= 6'd0;
      beat_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      sew_q   <= sew_d;
      evl_q   <= evl_d;
      beat_q  <= beat_d;
    end
  end

  // Payload is forced to zero whenever no beat is offered.
  always_comb begin
    run         = (state_q == S_RUN);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    op_valid    = run;
    op_reg_off  = run ? beat_q : 3'd0;
    op_elem_idx = run ? elem5 : '0;
    op_byte_en  = run ? be : 4'b0000;
    op_first    = run && (beat_q == 3'd0);
    op_last     = run && is_last;
  end

endmodule
